// File: rtl/fc_stream_adapter.sv
// fc_stream_adapter: streams a BiLSTM hidden vector into FC1 and replays its result as a stream; FC_ADAPTER_FRAME_CHECK_EN enables s_last framing checks
module fc_stream_adapter #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DIM     = 200,
  parameter int OUT_DIM    = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  output logic                         fc_start,
  output logic signed [DATA_WIDTH-1:0] fc_in_vector [0:IN_DIM-1],
  input  logic signed [DATA_WIDTH-1:0] fc_out_vector [0:OUT_DIM-1],
  input  logic                         fc_out_done,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         frame_err
);
  localparam int WW = $clog2(IN_DIM);
  localparam int RW = $clog2(OUT_DIM);
  typedef enum logic [1:0] {LOAD, FIRE, WAIT, DRAIN} state_t;
  state_t state;
  logic [WW-1:0] wr_idx;
  logic [RW-1:0] rd_idx;
  logic signed [DATA_WIDTH-1:0] out_buf [0:OUT_DIM-1];
  logic beat, wr_last, rd_last, bad;
  assign s_ready = (state == LOAD) && !rst;
  assign beat    = s_valid && s_ready;
  assign wr_last = wr_idx == WW'(IN_DIM - 1);
  assign rd_last = rd_idx == RW'(OUT_DIM - 1);
  assign busy    = state != LOAD;
  assign m_valid = state == DRAIN;
  assign m_last  = m_valid && rd_last;
  assign m_data  = out_buf[rd_idx];
`ifdef FC_ADAPTER_FRAME_CHECK_EN
  assign bad = beat && (s_last != wr_last);
`else
  assign bad = s_last & 1'b0;
`endif
  // Frame load, FC start/done handshake and result drain sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_idx    <= '0;
      rd_idx    <= '0;
      fc_start  <= 1'b0;
      frame_err <= 1'b0;
      for (int k = 0; k < IN_DIM; k++) fc_in_vector[k] <= '0;
      for (int k = 0; k < OUT_DIM; k++) out_buf[k] <= '0;
    end else begin
      fc_start  <= 1'b0;
      frame_err <= bad;
      case (state)
        LOAD: if (beat) begin
          fc_in_vector[wr_idx] <= s_data;
          if (bad) wr_idx <= '0;
          else if (wr_last) begin
            wr_idx   <= '0;
            fc_start <= 1'b1;
            state    <= FIRE;
          end else wr_idx <= wr_idx + 1'b1;
        end
        FIRE: state <= WAIT;
        WAIT: if (fc_out_done) begin
          for (int k = 0; k < OUT_DIM; k++) out_buf[k] <= fc_out_vector[k];
          state <= DRAIN;
        end
        DRAIN: if (m_ready) begin
          rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
          if (rd_last) state <= LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_stream_adapter.sv
// tb_fc_stream_adapter: scoreboard bench for fc_stream_adapter with a behavioural FC layer model
module tb_fc_stream_adapter;
  localparam int IN_DIM = 200;
  localparam int OUT_DIM = 100;
  localparam int FC_LAT = 10;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, s_last = 0, fc_start, fc_out_done, m_valid, m_ready = 0, m_last, busy, frame_err;
  logic [15:0] s_data = 0, m_data;
  logic signed [15:0] fc_in_vector [0:IN_DIM-1];
  logic signed [15:0] fc_out_vector [0:OUT_DIM-1];
  logic model_done = 0, stray = 0, ready_val = 0, ready_rand = 0;
  logic [15:0] cur_frame [0:IN_DIM-1];
  logic [15:0] last_frame [0:IN_DIM-1];
  logic [16:0] sb [$];
  int cyc = 0, errors = 0, checks = 0, starts = 0, out_cnt = 0, out_k = 0;
  int acc_cyc = -10, done_cyc = -10, first_cyc = 0, last_cyc = 0, done_len = 1;
  assign fc_out_done = model_done | stray;
  fc_stream_adapter #(.DATA_WIDTH(16), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fc_start(fc_start), .fc_in_vector(fc_in_vector), .fc_out_vector(fc_out_vector), .fc_out_done(fc_out_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // FC model: out[k] = in[k] + 0x1000, done FC_LAT cycles after start for done_len cycles
  initial begin
    for (int k = 0; k < OUT_DIM; k++) fc_out_vector[k] = '0;
    forever begin
      @(negedge clk);
      if (fc_start && !rst) begin
        int diffs = 0;
        starts++;
        check("start_lat", cyc, acc_cyc + 1);
        for (int k = 0; k < IN_DIM; k++) diffs += int'(16'(fc_in_vector[k]) !== last_frame[k]);
        check("in_vec", diffs, 0);
        for (int k = 0; k < OUT_DIM; k++) fc_out_vector[k] = fc_in_vector[k] + 16'sh1000;
        repeat (FC_LAT) @(posedge clk);
        #1;
        done_cyc = cyc;
        model_done = 1;
        repeat (done_len) @(posedge clk);
        #1;
        model_done = 0;
        diffs = 0;
        for (int k = 0; k < IN_DIM; k++) diffs += int'(16'(fc_in_vector[k]) !== last_frame[k]);
        check("in_hold", diffs, 0);
      end
    end
  end
  // Output monitor: scoreboard pop, backpressure hold, latency and ready/busy exclusivity
  logic pv = 0, pmv = 0, pl = 0, post_last = 0;
  logic [15:0] pd = 0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 0; pmv = 0; post_last = 0;
    end else begin
      logic [16:0] e;
      if (post_last) begin
        check("busy_fall", busy, 0);
        check("ready_back", s_ready, 1);
      end
      post_last = 0;
      check("ready_excl", s_ready & busy, 0);
`ifndef FC_ADAPTER_FRAME_CHECK_EN
      check("ferr_off", frame_err, 0);
`endif
      if (m_valid && !pmv) check("lat_out", cyc, done_cyc + 1);
      if (pv) begin
        check("hold_data", m_data, pd);
        check("hold_last", m_last, pl);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) check("spurious", 1, 0);
        else begin
          e = sb.pop_front();
          check("m_data", m_data, e[15:0]);
          check("m_last", m_last, e[16]);
        end
        out_cnt++;
        if (out_k == 0) first_cyc = cyc;
        if (m_last) begin
          last_cyc = cyc;
          out_k = 0;
          post_last = 1;
        end else out_k++;
      end
      pv = m_valid && !m_ready; pd = m_data; pl = m_last; pmv = m_valid;
    end
  end
  task automatic send_frame(input bit rnd, input int err_at);
    int n = err_at >= 0 ? err_at + 1 : IN_DIM;
    for (int i = 0; i < n; i++) begin
      bit acc = 0;
      int t = 0;
      s_data = cur_frame[i];
      s_last = (i == n - 1);
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!acc && t < 2000) begin
        @(negedge clk);
        acc = s_valid && s_ready;
        if (acc && i == n - 1 && err_at < 0) begin
          acc_cyc = cyc;
          last_frame = cur_frame;
          for (int k = 0; k < OUT_DIM; k++) sb.push_back({k == OUT_DIM - 1, 16'(cur_frame[k] + 16'h1000)});
        end
        @(posedge clk);
        #1;
        t++;
        if (!acc) s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!acc) begin
        check("in_timeout", 0, 1);
        s_valid = 0;
        return;
      end
    end
    s_valid = 0;
    s_last = 0;
    if (err_at >= 0) begin
      @(negedge clk);
      check("frame_err", frame_err, 1);
    end
  endtask
  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) check("drain_timeout", 0, 1);
    #1;
  endtask
  task automatic fill_random();
    for (int k = 0; k < IN_DIM; k++) cur_frame[k] = 16'($urandom);
  endtask
  initial begin
    int s0, c0, t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", s_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", fc_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_vec0", 16'(fc_in_vector[0]), 0);
    check("rst_vec199", 16'(fc_in_vector[IN_DIM-1]), 0);
    @(posedge clk);
    #1;
    ready_val = 1;
    for (int k = 0; k < IN_DIM; k++) cur_frame[k] = 16'(k);
    send_frame(0, -1);
    wait_drain();
    check("one_start", starts, 1);
    check("drain_span", last_cyc - first_cyc, OUT_DIM - 1);
    ready_rand = 1;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(1, -1);
    end
    wait_drain();
    check("rand_starts", starts, 4);
    ready_rand = 0;
    stray = 1;
    repeat (2) @(posedge clk);
    #1 stray = 0;
    @(negedge clk);
    check("stray_ignored", m_valid, 0);
    @(posedge clk);
    #1;
    done_len = 3;
    c0 = out_cnt;
    fill_random();
    send_frame(0, -1);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check("single_capture", out_cnt - c0, OUT_DIM);
    done_len = 1;
    c0 = out_cnt;
    fill_random();
    send_frame(0, -1);
    t = 0;
    while (out_cnt < c0 + 40 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 1000) check("mid_timeout", 0, 1);
    #1 rst = 1;
    s0 = starts;
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    out_k = 0;
    @(negedge clk);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_no_restart", starts, s0);
    @(posedge clk);
    #1;
    fill_random();
    send_frame(0, -1);
    wait_drain();
    check("post_rst_start", starts, s0 + 1);
`ifdef FC_ADAPTER_FRAME_CHECK_EN
    s0 = starts;
    fill_random();
    send_frame(0, 50);
    repeat (5) @(posedge clk);
    #1;
    check("drop_no_start", starts, s0);
    check("drop_busy", busy, 0);
    fill_random();
    send_frame(0, -1);
    wait_drain();
    check("after_drop_start", starts, s0 + 1);
`endif
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
